monitor_event_stamper: RTL and testbench

//  Front-end ingress stage of the RTLola monitor: samples per-input values and new-flags,

---
 rtl/monitor_event_pkg.sv | 16 +
 rtl/monitor_event_fifo.sv | 45 ++++
 rtl/monitor_event_stamper.sv | 97 +++++++++
 tb/tb_monitor_event_stamper.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/monitor_event_pkg.sv
// Shared defaults and event record for the monitor ingress stamper.
// The optional drop counter is enabled by defining STAMPER_DROP_CNT_EN.
package monitor_event_pkg;

   localparam int MON_NUM_INPUTS = 3;
   localparam int MON_DATA_W     = 64;
   localparam int MON_TS_W       = 64;
   localparam int MON_DEPTH      = 4;

   typedef struct packed {
      logic [MON_TS_W-1:0]                  ts;
      logic [MON_NUM_INPUTS-1:0]            new_mask;
      logic [MON_NUM_INPUTS*MON_DATA_W-1:0] data;
   } mon_event_t;

endpackage

// File: rtl/monitor_event_fifo.sv
// Register-array FIFO over an arbitrary packed record type.
// Occupancy comes from read/write pointers that carry one extra wrap bit.
module monitor_event_fifo
   import monitor_event_pkg::*;
#(
   parameter type T     = mon_event_t,
   parameter int  DEPTH = MON_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  T            push_data,
   input  logic        pop,
   output T            head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   T            mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only observed between push and pop.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/monitor_event_stamper.sv
// Ingress stage: timestamps sampled input events and queues them for the core.
// Define STAMPER_DROP_CNT_EN to expose the saturating drop_cnt output.
module monitor_event_stamper
   import monitor_event_pkg::*;
#(
   parameter int NUM_INPUTS = MON_NUM_INPUTS,
   parameter int DATA_W     = MON_DATA_W,
   parameter int TS_W       = MON_TS_W,
   parameter int DEPTH      = MON_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]        in_new,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic [NUM_INPUTS*DATA_W-1:0] ev_data,
   output logic [NUM_INPUTS-1:0]        ev_new,
   output logic [TS_W-1:0]              ev_ts,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         overflow
`ifdef STAMPER_DROP_CNT_EN
   ,
   output logic [15:0]                  drop_cnt
`endif
);

   typedef struct packed {
      logic [TS_W-1:0]              ts;
      logic [NUM_INPUTS-1:0]        new_mask;
      logic [NUM_INPUTS*DATA_W-1:0] data;
   } ev_t;

   logic [TS_W-1:0]              ts;
   logic [NUM_INPUTS*DATA_W-1:0] masked;
   ev_t                          cap_ev;
   ev_t                          head;
   logic                         capture;
   logic                         push;
   logic                         pop;
   logic                         drop;
   logic                         full;
   logic                         empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    ts <= '0;
      else if (en) ts <= ts + 1'b1;
   end

   always_comb begin
      masked = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (in_new[i]) masked[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
      end
   end

   assign cap_ev   = '{ts: ts, new_mask: in_new, data: masked};
   assign capture  = en & (|in_new);
   assign pop      = en & ev_valid & ev_ready;
   // A pop in the same cycle frees the slot the incoming event needs.
   assign push     = capture & (~full | pop);
   assign drop     = capture & full & ~pop;

   monitor_event_fifo #(
      .T     (ev_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (cap_ev),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign ev_valid = ~empty;
   assign ev_data  = empty ? '0 : head.data;
   assign ev_new   = empty ? '0 : head.new_mask;
   assign ev_ts    = empty ? '0 : head.ts;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

`ifdef STAMPER_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_monitor_event_stamper.sv
// Directed bench for monitor_event_stamper; inputs change and outputs are sampled on negedge.
// Covers drop_cnt as well when STAMPER_DROP_CNT_EN is defined.
module tb_monitor_event_stamper;

   logic         clk;
   logic         rst;
   logic         en;
   logic [191:0] in_data;
   logic [2:0]   in_new;
   logic         ev_valid;
   logic         ev_ready;
   logic [191:0] ev_data;
   logic [2:0]   ev_new;
   logic [63:0]  ev_ts;
   logic [2:0]   level;
   logic         overflow;
`ifdef STAMPER_DROP_CNT_EN
   logic [15:0]  drop_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [63:0]  ts;
      logic [2:0]   nw;
      logic [191:0] d;
   } exp_t;
   exp_t q[$];

   logic [63:0] ts_m;

   monitor_event_stamper dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_data  (in_data),
      .in_new   (in_new),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_data  (ev_data),
      .ev_new   (ev_new),
      .ev_ts    (ev_ts),
      .level    (level),
      .overflow (overflow)
`ifdef STAMPER_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter as the block should see it: cleared by reset, frozen by en=0.
   always @(posedge clk or negedge rst) begin
      if (!rst)    ts_m <= '0;
      else if (en) ts_m <= ts_m + 64'd1;
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the event is captured on the next posedge.
   task automatic drive_ev(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input bit stored);
      exp_t e;
      in_new  = m;
      in_data = {c, b, a};
      if (stored) begin
         e.ts = ts_m;
         e.nw = m;
         e.d  = {m[2] ? c : 64'd0, m[1] ? b : 64'd0, m[0] ? a : 64'd0};
         q.push_back(e);
      end
      @(negedge clk);
      in_new = '0;
   endtask

   task automatic check_head(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_valid_unexp"}, 192'(ev_valid), 192'd0);
      end else begin
         e = q.pop_front();
         chk({tag, "_valid"}, 192'(ev_valid), 192'd1);
         chk({tag, "_ts"},    192'(ev_ts),    192'(e.ts));
         chk({tag, "_new"},   192'(ev_new),   192'(e.nw));
         chk({tag, "_data"},  ev_data,        e.d);
      end
   endtask

   task automatic drain(input int n, input string tag);
      ev_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check_head($sformatf("%s%0d", tag, i));
         @(negedge clk);
      end
      ev_ready = 1'b0;
      chk({tag, "_empty"}, 192'(ev_valid), 192'd0);
      chk({tag, "_lvl0"},  192'(level),    192'd0);
   endtask

   logic [63:0] t0;

   initial begin
      rst = 1'b0; en = 1'b1; in_new = '0; in_data = '0; ev_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 192'(ev_valid), 192'd0);
      chk("rst_level", 192'(level),    192'd0);
      chk("rst_ovf",   192'(overflow), 192'd0);
      chk("rst_ts",    192'(ev_ts),    192'd0);
      chk("rst_new",   192'(ev_new),   192'd0);
      chk("rst_data",  ev_data,        192'd0);
`ifdef STAMPER_DROP_CNT_EN
      chk("rst_dcnt",  192'(drop_cnt), 192'd0);
`endif

      // First event captured at timestamp 500, popped immediately.
      rst = 1'b1;
      repeat (500) @(posedge clk);
      @(negedge clk);
      ev_ready = 1'b1;
      drive_ev(3'b111, 64'd1, 64'd1, 64'd1, 1'b1);
      chk("ts500_ts", 192'(ev_ts), 192'd500);
      check_head("ts500");
      @(negedge clk);
      chk("ts500_one_cycle", 192'(ev_valid), 192'd0);

      // Partial mask zeroes the unflagged stream.
      drive_ev(3'b011, 64'd6, 64'd6, 64'hDEAD, 1'b1);
      chk("mask_s2_zero", ev_data[191:128], 192'd0);
      check_head("mask");
      @(negedge clk);
      chk("mask_popped", 192'(ev_valid), 192'd0);

      // Fill to DEPTH, then capture together with a pop: no drop.
      ev_ready = 1'b0;
      for (int k = 1; k <= 4; k++) drive_ev(3'b001 << (k % 3), 64'(k), 64'(k + 10), 64'(k + 20), 1'b1);
      chk("fill_level", 192'(level), 192'd4);
      ev_ready = 1'b1;
      check_head("fullpop_head");
      drive_ev(3'b101, 64'h55, 64'h66, 64'h77, 1'b1);
      ev_ready = 1'b0;
      chk("fullpop_level", 192'(level),    192'd4);
      chk("fullpop_ovf",   192'(overflow), 192'd0);
      drain(4, "fullpop_drain");

      // Enable low: strobes ignored, timestamp and queue frozen.
      drive_ev(3'b010, 64'd0, 64'hA1, 64'd0, 1'b1);
      drive_ev(3'b100, 64'd0, 64'd0, 64'hA2, 1'b1);
      en = 1'b0;
      t0 = ts_m;
      ev_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_new  = 3'b111;
         in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
      end
      in_new = '0;
      chk("frz_level", 192'(level),    192'd2);
      chk("frz_valid", 192'(ev_valid), 192'd1);
      chk("frz_ts",    192'(ev_ts),    192'(q[0].ts));
      chk("frz_ovf",   192'(overflow), 192'd0);
      ev_ready = 1'b0;
      en = 1'b1;
      drive_ev(3'b001, 64'hB3, 64'd0, 64'd0, 1'b1);
      chk("frz_resume_ts", 192'(q[2].ts), 192'(t0));
      chk("frz_lvl3", 192'(level), 192'd3);

      // Reset with three events buffered.
      rst = 1'b0;
      #1;
      chk("rst2_valid", 192'(ev_valid), 192'd0);
      chk("rst2_level", 192'(level),    192'd0);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      drive_ev(3'b001, 64'hC0, 64'd0, 64'd0, 1'b1);
      chk("rst2_ts0", 192'(ev_ts), 192'd0);
      drain(1, "rst2");

      // Overflow: five events into four slots with the core stalled.
      for (int k = 1; k <= 5; k++) drive_ev(3'b111, 64'(k), 64'(k + 100), 64'(k + 200), k <= 4);
      chk("ovf_level", 192'(level),    192'd4);
      chk("ovf_flag",  192'(overflow), 192'd1);
`ifdef STAMPER_DROP_CNT_EN
      chk("ovf_dcnt",  192'(drop_cnt), 192'd1);
`endif
      drain(4, "ovf_drain");
      chk("ovf_sticky", 192'(overflow), 192'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
